// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and lane helpers for the data-memory arbiter
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPT,
    ST_WRITE,
    ST_RESP
  } state_t;

  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: lane_extract = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: lane_extract = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: lane_extract = word;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: r[{off, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    lane_merge = r;
  endfunction

  // Illegal size or an address not aligned to the access size.
  function automatic logic access_bad(input logic [1:0] off, input logic [1:0] size);
    case (size)
      SZ_BYTE: access_bad = 1'b0;
      SZ_HALF: access_bad = off[0];
      SZ_WORD: access_bad = (off != 2'b00);
      default: access_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// rtl/dmem_lane_unit.sv - combinational lane extract/extend and store merge
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_uns,
  output logic [31:0] o_ext,
  output logic [31:0] o_merged
);

  assign o_ext    = lane_extract(i_word, i_off, i_size, i_uns);
  assign o_merged = lane_merge(i_word, i_wdata, i_off, i_size);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester round-robin arbiter and sub-word access sequencer
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [1:0]        req0_size,
  input  logic              req0_unsigned,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [1:0]        req1_size,
  input  logic              req1_unsigned,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic              mem_wEn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              r_state;
  state_t              w_next;
  logic                r_last;
  logic                r_id;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [1:0]          r_size;
  logic                r_uns;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_accept;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [1:0]          w_sel_size;
  logic                w_sel_uns;
  logic                w_bad;
  logic [DATA_W-1:0]   w_ext;
  logic [DATA_W-1:0]   w_merged;
  logic                w_mem_active;

  // On a tie the requester that was not served last wins.
  assign w_gnt0 = req0_valid && (!req1_valid || r_last);
  assign w_gnt1 = req1_valid && (!req0_valid || !r_last);

  assign req0_ready = !rst && (r_state == ST_IDLE) && w_gnt0;
  assign req1_ready = !rst && (r_state == ST_IDLE) && w_gnt1;
  assign w_accept   = req0_ready || req1_ready;

  assign w_sel_we    = w_gnt1 ? req1_we       : req0_we;
  assign w_sel_addr  = w_gnt1 ? req1_addr     : req0_addr;
  assign w_sel_wdata = w_gnt1 ? req1_wdata    : req0_wdata;
  assign w_sel_size  = w_gnt1 ? req1_size     : req0_size;
  assign w_sel_uns   = w_gnt1 ? req1_unsigned : req0_unsigned;
  assign w_bad       = access_bad(w_sel_addr[1:0], w_sel_size);

  dmem_lane_unit u_lane (
    .i_word   (mem_rdata),
    .i_wdata  (r_wdata),
    .i_off    (r_addr[1:0]),
    .i_size   (r_size),
    .i_uns    (r_uns),
    .o_ext    (w_ext),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= SZ_BYTE;
      r_uns   <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id    <= w_gnt1;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_size  <= w_sel_size;
            r_uns   <= w_sel_uns;
            r_rdata <= '0;
            r_err   <= w_bad;
          end
        end
        // Stores keep the merged word in r_wdata so WRITE drives it directly.
        ST_CAPT: begin
          if (r_we) r_wdata <= w_merged;
          else      r_rdata <= w_ext;
        end
        ST_RESP: r_last <= r_id;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_bad)                                w_next = ST_RESP;
          else if (w_sel_we && w_sel_size == SZ_WORD) w_next = ST_WRITE;
          else                                      w_next = ST_READ;
        end
      end
      ST_READ:  w_next = ST_CAPT;
      ST_CAPT:  w_next = r_we ? ST_WRITE : ST_RESP;
      ST_WRITE: w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign w_mem_active = (r_state == ST_READ) || (r_state == ST_CAPT) || (r_state == ST_WRITE);

  assign mem_wEn   = (r_state == ST_WRITE);
  assign mem_addr  = w_mem_active ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = (r_state == ST_WRITE) ? r_wdata : '0;

  assign rsp0_valid = (r_state == ST_RESP) && !r_id;
  assign rsp1_valid = (r_state == ST_RESP) && r_id;
  assign rsp0_rdata = rsp0_valid ? r_rdata : '0;
  assign rsp1_rdata = rsp1_valid ? r_rdata : '0;
  assign rsp0_err   = rsp0_valid && r_err;
  assign rsp1_err   = rsp1_valid && r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we, req0_unsigned;
  logic [15:0] req0_addr;
  logic [31:0] req0_wdata;
  logic [1:0]  req0_size;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we, req1_unsigned;
  logic [15:0] req1_addr;
  logic [31:0] req1_wdata;
  logic [1:0]  req1_size;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic        mem_wEn;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_size(req0_size),
    .req0_unsigned(req0_unsigned),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_size(req1_size),
    .req1_unsigned(req1_unsigned),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_wEn(mem_wEn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous-read word memory standing in for data_memory.
  logic [31:0] tb_mem [0:16383];
  always @(posedge clk) begin
    if (mem_wEn) tb_mem[mem_addr[15:2]] <= mem_wdata;
    mem_rdata <= tb_mem[mem_addr[15:2]];
  end

  int          wen_cnt = 0;
  logic [15:0] last_waddr = 16'h0;
  logic [31:0] last_wdata = 32'h0;
  logic        addr_lo_bad = 1'b0;
  always @(negedge clk) begin
    if (mem_wEn) begin
      wen_cnt    <= wen_cnt + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
    end
    if (mem_addr[1:0] != 2'b00) addr_lo_bad <= 1'b1;
  end

  task automatic set_req(input int id, input logic v, input logic we, input logic [15:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic u);
    if (id == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = wd; req0_size = sz; req0_unsigned = u;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = wd; req1_size = sz; req1_unsigned = u;
    end
  endtask

  // One request: lat counts negedges from acceptance to the response cycle.
  task automatic do_req(input int id, input logic we, input logic [15:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic u,
                        output logic [31:0] rd, output logic er, output int lat, output logic to,
                        output logic [7:0] tr_wen, output logic [7:0] tr_act, output logic wrong);
    int n;
    logic got;
    rd = 32'h0; er = 1'b0; lat = 0; to = 1'b0; tr_wen = 8'h0; tr_act = 8'h0; wrong = 1'b0; got = 1'b0;
    @(negedge clk);
    set_req(id, 1'b1, we, a, wd, sz, u);
    #1;
    n = 0;
    while (!((id == 0) ? req0_ready : req1_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      to = 1'b1;
      set_req(id, 1'b0, 1'b0, 16'h0, 32'h0, 2'b00, 1'b0);
    end else begin
      @(negedge clk);
      set_req(id, 1'b0, 1'b0, 16'h0, 32'h0, 2'b00, 1'b0);
      lat = 1;
      while (!got && !to) begin
        tr_wen[lat-1] = mem_wEn;
        tr_act[lat-1] = (mem_addr != 16'h0);
        if ((id == 0) ? rsp1_valid : rsp0_valid) wrong = 1'b1;
        if ((id == 0) ? rsp0_valid : rsp1_valid) begin
          got = 1'b1;
          rd  = (id == 0) ? rsp0_rdata : rsp1_rdata;
          er  = (id == 0) ? rsp0_err : rsp1_err;
        end else if (lat >= 8) begin
          to = 1'b1;
        end else begin
          @(negedge clk);
          lat++;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_req(0, 1'b1, 1'b0, 16'h0040, 32'h0, 2'b10, 1'b0);
    set_req(1, 1'b1, 1'b0, 16'h0044, 32'h0, 2'b10, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready});
    end
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, rsp0_rdata, rsp1_rdata} !== 68'h0) begin
      errors++; $display("FAIL reset_rsp got v=%b%b e=%b%b d0=%h d1=%h want all 0",
                         rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, rsp0_rdata, rsp1_rdata);
    end
    checks++;
    if ({mem_wEn, mem_addr, mem_wdata} !== 49'h0) begin
      errors++; $display("FAIL reset_mem got wEn=%b addr=%h wdata=%h want 0", mem_wEn, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL first_tie got=%b want=10", {req0_ready, req1_ready});
    end
    set_req(0, 1'b0, 1'b0, 16'h0, 32'h0, 2'b00, 1'b0);
    set_req(1, 1'b0, 1'b0, 16'h0, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic test_word_store;
    logic [31:0] rd; logic er, to, wr; int lat, w0; logic [7:0] tw, ta;
    w0 = wen_cnt;
    do_req(0, 1'b1, 16'h0010, 32'h11111111, 2'b10, 1'b0, rd, er, lat, to, tw, ta, wr);
    @(negedge clk);
    checks++;
    if (to || wr || lat !== 2 || er !== 1'b0 || rd !== 32'h0 || tw[1:0] !== 2'b01) begin
      errors++; $display("FAIL word_store got to=%b wr=%b lat=%0d err=%b rd=%h wen=%b want lat=2 err=0 rd=0 wen=01",
                         to, wr, lat, er, rd, tw[1:0]);
    end
    checks++;
    if (wen_cnt - w0 !== 1 || last_waddr !== 16'h0010 || last_wdata !== 32'h11111111) begin
      errors++; $display("FAIL word_store_mem got n=%0d addr=%h data=%h want n=1 addr=0010 data=11111111",
                         wen_cnt - w0, last_waddr, last_wdata);
    end
    do_req(1, 1'b0, 16'h0010, 32'h0, 2'b10, 1'b0, rd, er, lat, to, tw, ta, wr);
    checks++;
    if (to || wr || lat !== 3 || er !== 1'b0 || rd !== 32'h11111111) begin
      errors++; $display("FAIL word_load got to=%b wr=%b lat=%0d err=%b rd=%h want lat=3 rd=11111111",
                         to, wr, lat, er, rd);
    end
  endtask

  task automatic test_sub_loads;
    logic [31:0] rd; logic er, to, wr; int lat; logic [7:0] tw, ta;
    logic [15:0] addrs [5] = '{16'h0022, 16'h0022, 16'h0022, 16'h0020, 16'h0023};
    logic [1:0]  sizes [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic        unss  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exps  [5] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01, 32'hFFFFFF80};
    do_req(1, 1'b1, 16'h0020, 32'h80FF7F01, 2'b10, 1'b0, rd, er, lat, to, tw, ta, wr);
    for (int i = 0; i < 5; i++) begin
      do_req(i % 2, 1'b0, addrs[i], 32'h0, sizes[i], unss[i], rd, er, lat, to, tw, ta, wr);
      checks++;
      if (to || wr || lat !== 3 || er !== 1'b0 || rd !== exps[i]) begin
        errors++; $display("FAIL sub_load[%0d] got to=%b wr=%b lat=%0d err=%b rd=%h want lat=3 rd=%h",
                           i, to, wr, lat, er, rd, exps[i]);
      end
    end
  endtask

  task automatic test_rmw;
    logic [31:0] rd; logic er, to, wr; int lat, w0; logic [7:0] tw, ta;
    do_req(0, 1'b1, 16'h0030, 32'hAABBCCDD, 2'b10, 1'b0, rd, er, lat, to, tw, ta, wr);
    w0 = wen_cnt;
    do_req(0, 1'b1, 16'h0031, 32'h12345655, 2'b00, 1'b0, rd, er, lat, to, tw, ta, wr);
    @(negedge clk);
    checks++;
    if (to || wr || lat !== 4 || er !== 1'b0 || rd !== 32'h0 || tw[3:0] !== 4'b0100 || ta[3:0] !== 4'b0111) begin
      errors++; $display("FAIL rmw_byte got to=%b lat=%0d err=%b rd=%h wen=%b act=%b want lat=4 wen=0100 act=0111",
                         to, lat, er, rd, tw[3:0], ta[3:0]);
    end
    checks++;
    if (wen_cnt - w0 !== 1 || last_waddr !== 16'h0030 || last_wdata !== 32'hAABB55DD) begin
      errors++; $display("FAIL rmw_byte_wdata got n=%0d addr=%h data=%h want n=1 addr=0030 data=AABB55DD",
                         wen_cnt - w0, last_waddr, last_wdata);
    end
    do_req(1, 1'b1, 16'h0032, 32'h0000BEEF, 2'b01, 1'b0, rd, er, lat, to, tw, ta, wr);
    checks++;
    if (to || lat !== 4 || er !== 1'b0) begin
      errors++; $display("FAIL rmw_half got to=%b lat=%0d err=%b want lat=4 err=0", to, lat, er);
    end
    do_req(0, 1'b0, 16'h0030, 32'h0, 2'b10, 1'b0, rd, er, lat, to, tw, ta, wr);
    checks++;
    if (to || rd !== 32'hBEEF55DD) begin
      errors++; $display("FAIL rmw_readback got to=%b rd=%h want BEEF55DD", to, rd);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er, to, wr; int lat, w0; logic [7:0] tw, ta;
    logic        wes   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] addrs [4] = '{16'h0002, 16'h0001, 16'h0004, 16'h0003};
    logic [1:0]  sizes [4] = '{2'b10, 2'b01, 2'b11, 2'b01};
    w0 = wen_cnt;
    for (int i = 0; i < 4; i++) begin
      do_req(i % 2, wes[i], addrs[i], 32'hDEADBEEF, sizes[i], 1'b0, rd, er, lat, to, tw, ta, wr);
      checks++;
      if (to || wr || lat !== 1 || er !== 1'b1 || rd !== 32'h0 || ta[0] !== 1'b0) begin
        errors++; $display("FAIL err[%0d] got to=%b wr=%b lat=%0d err=%b rd=%h act=%b want lat=1 err=1 rd=0 act=0",
                           i, to, wr, lat, er, rd, ta[0]);
      end
    end
    @(negedge clk);
    checks++;
    if (wen_cnt !== w0) begin
      errors++; $display("FAIL err_no_write got=%0d want=%0d", wen_cnt, w0);
    end
  endtask

  task automatic test_arbitration;
    logic [31:0] rd; logic er, to, wr; int lat; logic [7:0] tw, ta;
    int exp_gnt [4] = '{0, 1, 0, 1};
    int gid, n;
    logic got, both;
    do_req(0, 1'b1, 16'h0040, 32'hA0A0A0A0, 2'b10, 1'b0, rd, er, lat, to, tw, ta, wr);
    do_req(1, 1'b1, 16'h0044, 32'hB1B1B1B1, 2'b10, 1'b0, rd, er, lat, to, tw, ta, wr);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 16'h0040, 32'h0, 2'b10, 1'b0);
    set_req(1, 1'b1, 1'b0, 16'h0044, 32'h0, 2'b10, 1'b0);
    #1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        @(negedge clk); #1; n++;
      end
      both = req0_ready && req1_ready;
      gid  = req1_ready ? 1 : 0;
      checks++;
      if (n >= 20 || both || gid !== exp_gnt[g]) begin
        errors++; $display("FAIL arb_grant[%0d] got id=%0d both=%b timeout=%b want id=%0d",
                           g, gid, both, (n >= 20), exp_gnt[g]);
      end
      got = 1'b0; n = 0;
      while (!got && n < 10) begin
        @(negedge clk); #1; n++;
        got = rsp0_valid || rsp1_valid;
      end
      checks++;
      if (!got || rsp0_valid !== (gid == 0) || rsp1_valid !== (gid == 1) ||
          (gid == 0 ? rsp0_rdata : rsp1_rdata) !== (gid == 0 ? 32'hA0A0A0A0 : 32'hB1B1B1B1)) begin
        errors++; $display("FAIL arb_rsp[%0d] got v=%b%b d0=%h d1=%h want id=%0d", g,
                           rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, gid);
      end
    end
    set_req(0, 1'b0, 1'b0, 16'h0, 32'h0, 2'b00, 1'b0);
    set_req(1, 1'b0, 1'b0, 16'h0, 32'h0, 2'b00, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_rmw;
    logic [31:0] rd; logic er, to, wr; int lat, w0, n; logic [7:0] tw, ta;
    logic saw_rsp;
    w0 = wen_cnt; saw_rsp = 1'b0;
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 16'h0030, 32'h00000099, 2'b00, 1'b0);
    #1; n = 0;
    while (!req0_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 16'h0, 32'h0, 2'b00, 1'b0);
    @(negedge clk);
    checks++;
    if (n >= 20 || mem_addr !== 16'h0030 || mem_wEn !== 1'b0) begin
      errors++; $display("FAIL mid_capt got addr=%h wEn=%b want addr=0030 wEn=0", mem_addr, mem_wEn);
    end
    rst = 1'b1;
    @(negedge clk);
    saw_rsp = rsp0_valid || rsp1_valid;
    checks++;
    if (mem_wEn !== 1'b0) begin
      errors++; $display("FAIL mid_rst_wen got=%b want=0", mem_wEn);
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      saw_rsp = saw_rsp || rsp0_valid || rsp1_valid;
    end
    checks++;
    if (saw_rsp || wen_cnt !== w0 || tb_mem[12] !== 32'hBEEF55DD) begin
      errors++; $display("FAIL mid_rst_abort got rsp=%b nwen=%0d mem=%h want rsp=0 nwen=0 mem=BEEF55DD",
                         saw_rsp, wen_cnt - w0, tb_mem[12]);
    end
    do_req(1, 1'b0, 16'h0030, 32'h0, 2'b10, 1'b0, rd, er, lat, to, tw, ta, wr);
    checks++;
    if (to || wr || lat !== 3 || rd !== 32'hBEEF55DD) begin
      errors++; $display("FAIL mid_rst_next got to=%b lat=%0d rd=%h want lat=3 rd=BEEF55DD", to, lat, rd);
    end
    @(negedge clk);
    checks++;
    if (addr_lo_bad !== 1'b0) begin
      errors++; $display("FAIL mem_addr_lo got=%b want=0", addr_lo_bad);
    end
  endtask

  initial begin
    set_req(0, 1'b0, 1'b0, 16'h0, 32'h0, 2'b00, 1'b0);
    set_req(1, 1'b0, 1'b0, 16'h0, 32'h0, 2'b00, 1'b0);
    test_reset;
    test_word_store;
    test_sub_loads;
    test_rmw;
    test_errors;
    test_arbitration;
    test_reset_mid_rmw;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
